// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8-bit core sequencer.
// The instruction byte is laid out as [ALU_Op(4) Rd(2) Rs1(2)].
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_IRQ,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SHL = 4'h5,
    ALU_SHR = 4'h6,
    ALU_INC = 4'h7,
    ALU_DEC = 4'h8,
    ALU_MOV = 4'h9,
    ALU_NOT = 4'hA
  } alu_op_t;

  localparam logic [3:0] OP_SYS = 4'hF;
  localparam logic [7:0] IR_NOP = 8'h00;

  // System subcodes live in IR[3:2] when the opcode is OP_SYS.
  typedef enum logic [1:0] {
    SYS_RETI = 2'b00,
    SYS_HALT = 2'b01,
    SYS_EI   = 2'b10,
    SYS_DI   = 2'b11
  } sys_op_t;

  // The all-zero byte would decode as ADD R0,R0; it is the NOP, so it never writes.
  function automatic logic is_alu_write(input logic [7:0] ir);
    return (ir != IR_NOP) && (ir[7:4] <= 4'(ALU_NOT));
  endfunction

endpackage

// File: rtl/fetch_irq_controller.sv
// Two-cycle fetch/execute sequencer with a single-level interrupt: request capture,
// vectoring, return-PC save and RETI.
module fetch_irq_controller
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter logic [7:0] IRQ_VECTOR = 8'hF0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irq_req,
  input  logic [7:0] instruction,
  output logic [7:0] pc,
  output logic [3:0] alu_op,
  output logic [1:0] rd_sel,
  output logic [1:0] rs1_sel,
  output logic       reg_we,
  output logic       irq_ack,
  output logic       in_isr,
  output logic       halted
);

  state_t     state;
  logic [7:0] ir;
  logic [7:0] epc;
  logic       ie;
  logic       pend;

  logic       is_sys;
  sys_op_t    sys_op;
  logic       ie_next;

  assign is_sys = (ir[7:4] == OP_SYS);
  assign sys_op = sys_op_t'(ir[3:2]);

  // Interrupt enable as it will be after this instruction; EI/RETI take effect
  // in time for the exit decision of their own EXEC cycle.
  always_comb begin
    // NOTE: default first so every path assigns ie_next and no latch is inferred.
    ie_next = ie;
    if (is_sys) begin
      case (sys_op)
        SYS_RETI, SYS_EI: ie_next = 1'b1;
        SYS_DI:           ie_next = 1'b0;
        default:          ie_next = ie;
      endcase
    end
  end

  assign alu_op  = ir[7:4];
  assign rd_sel  = ir[3:2];
  assign rs1_sel = ir[1:0];
  assign reg_we  = (state == ST_EXEC) && is_alu_write(ir);
  assign irq_ack = (state == ST_IRQ);
  assign halted  = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= IR_NOP;
      epc    <= 8'h00;
      ie     <= 1'b0;
      pend   <= 1'b0;
      in_isr <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge state.
      if (state == ST_IRQ) pend <= 1'b0;
      else if (irq_req)    pend <= 1'b1;

      case (state)
        ST_FETCH: begin
          ir    <= instruction;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          ie <= ie_next;
          if (is_sys && sys_op == SYS_RETI) begin
            pc     <= epc;
            in_isr <= 1'b0;
            state  <= ST_FETCH;
          end else begin
            pc <= pc + 8'd1;
            if (pend && ie_next && !in_isr)      state <= ST_IRQ;
            else if (is_sys && sys_op == SYS_HALT) state <= ST_HALT;
            else                                  state <= ST_FETCH;
          end
        end
        ST_IRQ: begin
          epc    <= pc;
          pc     <= IRQ_VECTOR;
          in_isr <= 1'b1;
          ie     <= 1'b0;
          state  <= ST_FETCH;
        end
        ST_HALT: begin
          if (pend && ie) state <= ST_IRQ;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_irq_controller.sv
// Self-checking bench: an instruction-level reference model predicts every output
// each cycle; scripted programs pin the model with hand-derived values.
module tb_fetch_irq_controller;

  localparam logic [7:0] IRQ_VECTOR = 8'hF0;
  localparam int TRACE_LEN = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq_req = 1'b0;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic [3:0] alu_op;
  logic [1:0] rd_sel;
  logic [1:0] rs1_sel;
  logic       reg_we;
  logic       irq_ack;
  logic       in_isr;
  logic       halted;

  logic [7:0] mem [256];
  assign instruction = mem[pc];

  always #5 clk = ~clk;

  fetch_irq_controller #(.RESET_PC(8'h00), .IRQ_VECTOR(IRQ_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .instruction(instruction),
    .pc(pc), .alu_op(alu_op), .rd_sel(rd_sel), .rs1_sel(rs1_sel),
    .reg_we(reg_we), .irq_ack(irq_ack), .in_isr(in_isr), .halted(halted)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: architectural state only.
  logic [7:0] m_pc, m_ir, m_epc;
  bit         m_ie, m_pend, m_isr, m_halt;

  logic [7:0] exp_pc, exp_ir;
  bit         exp_we, exp_ack, exp_halt, exp_isr;
  bit         chk_en = 1'b0;
  int         cyc_count = 0;
  bit         irq_pat [TRACE_LEN];

  logic [7:0] tr_pc [TRACE_LEN];
  logic [7:0] tr_ir [TRACE_LEN];
  logic       tr_we [TRACE_LEN];
  logic       tr_ack [TRACE_LEN];
  logic       tr_isr [TRACE_LEN];
  logic       tr_halt [TRACE_LEN];

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, exp_pc);
      check("ir_fields", {alu_op, rd_sel, rs1_sel}, exp_ir);
      check("reg_we", reg_we, exp_we);
      check("irq_ack", irq_ack, exp_ack);
      check("halted", halted, exp_halt);
      check("in_isr", in_isr, exp_isr);
      tr_pc[cyc_count]   = pc;
      tr_ir[cyc_count]   = {alu_op, rd_sel, rs1_sel};
      tr_we[cyc_count]   = reg_we;
      tr_ack[cyc_count]  = irq_ack;
      tr_isr[cyc_count]  = in_isr;
      tr_halt[cyc_count] = halted;
    end
  end

  // One clock of the machine: publish expectations, drive irq_req, then
  // capture the request into the pending flag (entry clears take priority).
  task automatic cyc(input bit we, input bit ack, input bit clr);
    exp_pc   = m_pc;
    exp_ir   = m_ir;
    exp_we   = we;
    exp_ack  = ack;
    exp_halt = m_halt;
    exp_isr  = m_isr;
    @(negedge clk);
    irq_req = irq_pat[cyc_count];
    @(posedge clk);
    if (clr)          m_pend = 1'b0;
    else if (irq_req) m_pend = 1'b1;
    #1 cyc_count++;
  endtask

  task automatic irq_entry();
    m_halt = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    m_epc = m_pc;
    m_pc  = IRQ_VECTOR;
    m_isr = 1'b1;
    m_ie  = 1'b0;
  endtask

  task automatic model_run(input int n);
    logic [3:0] op;
    logic [1:0] sub;
    bit         p, we, sys;
    while (cyc_count < n) begin
      if (m_halt) begin
        p = m_pend;
        cyc(1'b0, 1'b0, 1'b0);
        if (p && m_ie) irq_entry();
      end else begin
        cyc(1'b0, 1'b0, 1'b0);
        m_ir = mem[m_pc];
        op  = m_ir[7:4];
        sub = m_ir[3:2];
        sys = (op == 4'hF);
        we  = (m_ir != 8'h00) && (op <= 4'hA);
        p   = m_pend;
        cyc(we, 1'b0, 1'b0);
        if (sys && sub == 2'b00) begin
          m_pc  = m_epc;
          m_isr = 1'b0;
          m_ie  = 1'b1;
        end else begin
          m_pc = m_pc + 8'd1;
          if (sys && sub == 2'b10) m_ie = 1'b1;
          if (sys && sub == 2'b11) m_ie = 1'b0;
          if (p && m_ie && !m_isr)      irq_entry();
          else if (sys && sub == 2'b01) m_halt = 1'b1;
        end
      end
    end
  endtask

  task automatic run_segment(input int n);
    @(negedge clk);
    rst_n   = 1'b0;
    irq_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc = 8'h00; m_ir = 8'h00; m_epc = 8'h00;
    m_ie = 1'b0; m_pend = 1'b0; m_isr = 1'b0; m_halt = 1'b0;
    cyc_count = 0;
    chk_en    = 1'b1;
    model_run(n);
    chk_en = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < TRACE_LEN; i++) irq_pat[i] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;

    // ALU ops 0x0..0xA at 0..10, first one ADD R0,R1.
    clear_prog();
    mem[0] = 8'h01;
    for (int i = 1; i <= 10; i++) mem[i] = {4'(i), 4'($urandom_range(0, 15))};
    run_segment(40);
    check("t1_pc_reset", tr_pc[0], 8'h00);
    check("t1_we_fetch", tr_we[0], 1'b0);
    check("t1_we_exec", tr_we[1], 1'b1);
    check("t1_fields_exec", tr_ir[1], 8'h01);
    check("t1_pc_after", tr_pc[2], 8'h01);
    check("t1_pc_cadence", tr_pc[20], 8'h0A);
    check("t1_op_last", tr_ir[21][7:4], 4'hA);
    check("t1_we_last", tr_we[21], 1'b1);

    // NOP sweep across the 8-bit wrap.
    clear_prog();
    run_segment(518);
    sum = 0;
    for (int i = 0; i < 518; i++) sum += int'(tr_we[i]);
    check("t2_no_writes", sum, 0);
    check("t2_pc_ff", tr_pc[510], 8'hFF);
    check("t2_pc_wrap", tr_pc[512], 8'h00);

    // EI, pulse during instruction 1, RETI returns to 2.
    clear_prog();
    mem[0] = 8'hF8; mem[1] = 8'h25; mem[IRQ_VECTOR] = 8'hF0;
    irq_pat[2] = 1'b1;
    run_segment(20);
    check("t3_ack", tr_ack[4], 1'b1);
    check("t3_vector", tr_pc[5], IRQ_VECTOR);
    check("t3_in_isr", tr_isr[5], 1'b1);
    check("t3_return_pc", tr_pc[7], 8'h02);
    check("t3_isr_clear", tr_isr[7], 1'b0);

    // Request held through the handler: one instruction at epc before re-entry.
    clear_prog();
    mem[0] = 8'hF8;
    for (int i = 1; i < 9; i++) mem[i] = 8'h11 + 8'(i);
    mem[IRQ_VECTOR] = 8'h23; mem[IRQ_VECTOR + 1] = 8'hF0;
    for (int i = 3; i < TRACE_LEN; i++) irq_pat[i] = 1'b1;
    run_segment(40);
    check("t4_first_ack", tr_ack[6], 1'b1);
    sum = 0;
    for (int i = 7; i <= 12; i++) sum += int'(tr_ack[i]);
    check("t4_no_nesting", sum, 0);
    check("t4_epc_return", tr_pc[11], 8'h03);
    check("t4_reentry", tr_ack[13], 1'b1);

    // DI masks the request; EI vectors right after its own EXEC.
    clear_prog();
    mem[0] = 8'hFC; mem[1] = 8'h35; mem[2] = 8'h46; mem[3] = 8'hF8;
    mem[IRQ_VECTOR] = 8'hF0;
    irq_pat[1] = 1'b1;
    run_segment(20);
    sum = 0;
    for (int i = 0; i <= 7; i++) sum += int'(tr_ack[i]);
    check("t5_masked", sum, 0);
    check("t5_ack_after_ei", tr_ack[8], 1'b1);
    check("t5_vector", tr_pc[9], IRQ_VECTOR);

    // HALT at 5 with interrupts enabled, woken by a request.
    clear_prog();
    mem[0] = 8'hF8; mem[1] = 8'h12; mem[2] = 8'h57; mem[3] = 8'h9A; mem[4] = 8'hA3;
    mem[5] = 8'hF4; mem[IRQ_VECTOR] = 8'hF0;
    irq_pat[20] = 1'b1;
    run_segment(30);
    check("t6_halted", tr_halt[12], 1'b1);
    check("t6_pc_frozen", tr_pc[12], 8'h06);
    check("t6_pc_still", tr_pc[20], 8'h06);
    check("t6_ack", tr_ack[22], 1'b1);
    check("t6_vector", tr_pc[23], IRQ_VECTOR);
    check("t6_epc", tr_pc[25], 8'h06);

    // Asynchronous reset while halted.
    clear_prog();
    mem[0] = 8'hF4;
    run_segment(8);
    @(negedge clk);
    check("t7_halt_before", halted, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_pc", pc, 8'h00);
    check("t7_async_halted", halted, 1'b0);

    // Randomized programs and request patterns.
    for (int s = 0; s < 3; s++) begin
      clear_prog();
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:2] == 6'b111101 && $urandom_range(0, 3) != 0) mem[i] = 8'hF8;
      end
      mem[0] = 8'hF8;
      for (int i = 0; i < TRACE_LEN; i++) irq_pat[i] = ($urandom_range(0, 7) == 0);
      run_segment(1200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
